axi4_burst_sram: RTL

AXI4_BURST_SRAM -- requirements
Module: axi4_burst_sram

---
 rtl/axi4_burst_pkg.sv | 44 ++++
 rtl/sram_dp_be.sv | 37 +++
 rtl/axi4_burst_sram.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi4_burst_pkg.sv
// Shared AXI4 burst/response encodings, FSM states and burst address stepping
// for axi4_burst_sram (WRAP support is enabled by AXI4_BURST_SRAM_WRAP_EN).
package axi4_burst_pkg;

  localparam logic [1:0] BURST_FIXED = 2'd0;
  localparam logic [1:0] BURST_INCR  = 2'd1;
  localparam logic [1:0] BURST_WRAP  = 2'd2;
  localparam logic [1:0] BURST_RSVD  = 2'd3;

  localparam logic [1:0] RESP_OKAY   = 2'd0;
  localparam logic [1:0] RESP_SLVERR = 2'd2;
  localparam logic [1:0] RESP_DECERR = 2'd3;

  typedef enum logic [1:0] {
    W_IDLE,
    W_DATA,
    W_RESP
  } wr_state_e;

  typedef enum logic [1:0] {
    R_IDLE,
    R_FETCH,
    R_DATA
  } rd_state_e;

  function automatic logic wrap_len_ok(input logic [7:0] len);
    return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
  endfunction

  // Operates on word indices; for WRAP the boundary is (len+1) words, so len
  // itself is the in-window mask. The caller reduces the result to the memory size.
  function automatic logic [31:0] next_addr(input logic [31:0] idx,
                                            input logic [1:0]  burst,
                                            input logic [7:0]  len);
    logic [31:0] mask;
    mask = {24'd0, len};
    case (burst)
      BURST_FIXED: next_addr = idx;
      BURST_WRAP:  next_addr = (idx & ~mask) | ((idx + 32'd1) & mask);
      default:     next_addr = idx + 32'd1;
    endcase
  endfunction

endpackage

// File: rtl/sram_dp_be.sv
// Simple dual-port RAM: one synchronous read port, one byte-enabled write port.
// Read-first on a same-cycle read/write of one word; contents are never reset.
module sram_dp_be #(
  parameter int unsigned DWIDTH     = 32,
  parameter int unsigned DEPTH_LOG2 = 10
) (
  input  logic                    clk,
  input  logic                    we,
  input  logic [DEPTH_LOG2-1:0]   waddr,
  input  logic [DWIDTH-1:0]       wdata,
  input  logic [DWIDTH/8-1:0]     wbe,
  input  logic                    re,
  input  logic [DEPTH_LOG2-1:0]   raddr,
  output logic [DWIDTH-1:0]       rdata
);

  localparam int unsigned NBYTES = DWIDTH / 8;

  logic [DWIDTH-1:0] mem_q [2**DEPTH_LOG2];
  logic [DWIDTH-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (re) begin
      rdata_q <= mem_q[raddr];
    end
    if (we) begin
      for (int unsigned i = 0; i < NBYTES; i++) begin
        if (wbe[i]) begin
          mem_q[waddr][i*8 +: 8] <= wdata[i*8 +: 8];
        end
      end
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/axi4_burst_sram.sv
// AXI4 burst slave over a byte-enabled SRAM with independent read/write FSMs.
// Define AXI4_BURST_SRAM_WRAP_EN to accept WRAP bursts (len 1/3/7/15).
module axi4_burst_sram
  import axi4_burst_pkg::*;
#(
  parameter int unsigned IWIDTH     = 1,
  parameter int unsigned DWIDTH     = 32,
  parameter int unsigned AWIDTH     = 32,
  parameter int unsigned DEPTH_LOG2 = 10
) (
  input  logic                  s00_axi_aclk,
  input  logic                  s00_axi_aresetn,
  input  logic [IWIDTH-1:0]     s00_axi_awid,
  input  logic [AWIDTH-1:0]     s00_axi_awaddr,
  input  logic [7:0]            s00_axi_awlen,
  input  logic [2:0]            s00_axi_awsize,
  input  logic [1:0]            s00_axi_awburst,
  input  logic                  s00_axi_awvalid,
  output logic                  s00_axi_awready,
  input  logic [DWIDTH-1:0]     s00_axi_wdata,
  input  logic [DWIDTH/8-1:0]   s00_axi_wstrb,
  input  logic                  s00_axi_wlast,
  input  logic                  s00_axi_wvalid,
  output logic                  s00_axi_wready,
  output logic [IWIDTH-1:0]     s00_axi_bid,
  output logic [1:0]            s00_axi_bresp,
  output logic                  s00_axi_bvalid,
  input  logic                  s00_axi_bready,
  input  logic [IWIDTH-1:0]     s00_axi_arid,
  input  logic [AWIDTH-1:0]     s00_axi_araddr,
  input  logic [7:0]            s00_axi_arlen,
  input  logic [2:0]            s00_axi_arsize,
  input  logic [1:0]            s00_axi_arburst,
  input  logic                  s00_axi_arvalid,
  output logic                  s00_axi_arready,
  output logic [IWIDTH-1:0]     s00_axi_rid,
  output logic [DWIDTH-1:0]     s00_axi_rdata,
  output logic [1:0]            s00_axi_rresp,
  output logic                  s00_axi_rlast,
  output logic                  s00_axi_rvalid,
  input  logic                  s00_axi_rready
);

  localparam int unsigned ADDR_LSB = $clog2(DWIDTH / 8);
  localparam int unsigned IDX_HI   = DEPTH_LOG2 + ADDR_LSB;
  localparam logic [31:0] DEPTH_MASK = 32'((64'd1 << DEPTH_LOG2) - 64'd1);
`ifdef AXI4_BURST_SRAM_WRAP_EN
  localparam bit WRAP_EN = 1'b1;
`else
  localparam bit WRAP_EN = 1'b0;
`endif

  // Whole-burst response decided at the address handshake; SLVERR outranks DECERR.
  function automatic logic [1:0] classify(input logic [AWIDTH-IDX_HI-1:0] hi,
                                          input logic [2:0] size,
                                          input logic [1:0] burst,
                                          input logic [7:0] len);
    if ((size != 3'(ADDR_LSB)) || (burst == BURST_RSVD) ||
        ((burst == BURST_WRAP) && !(WRAP_EN && wrap_len_ok(len)))) begin
      return RESP_SLVERR;
    end
    if (hi != '0) begin
      return RESP_DECERR;
    end
    return RESP_OKAY;
  endfunction

  logic unused_addr_lsb;
  assign unused_addr_lsb = ^{s00_axi_awaddr[ADDR_LSB-1:0], s00_axi_araddr[ADDR_LSB-1:0]};

  logic                  ram_we;
  logic                  ram_re;
  logic [DEPTH_LOG2-1:0] ram_raddr;
  logic [DWIDTH-1:0]     ram_rdata;

  // ---------------- write channel ----------------
  wr_state_e       wr_state_q, wr_state_d;
  logic [IWIDTH-1:0] wr_id_q, wr_id_d;
  logic [31:0]     wr_idx_q, wr_idx_d, wr_next;
  logic [1:0]      wr_burst_q, wr_burst_d;
  logic [7:0]      wr_len_q, wr_len_d;
  logic [7:0]      wr_cnt_q, wr_cnt_d;
  logic [1:0]      wr_resp_q, wr_resp_d;
  logic            wr_proto_q, wr_proto_d;
  logic            wr_over_q, wr_over_d;

  always_comb begin
    wr_state_d = wr_state_q;
    wr_id_d    = wr_id_q;
    wr_idx_d   = wr_idx_q;
    wr_burst_d = wr_burst_q;
    wr_len_d   = wr_len_q;
    wr_cnt_d   = wr_cnt_q;
    wr_resp_d  = wr_resp_q;
    wr_proto_d = wr_proto_q;
    wr_over_d  = wr_over_q;
    wr_next    = next_addr(wr_idx_q, wr_burst_q, wr_len_q) & DEPTH_MASK;
    s00_axi_awready = 1'b0;
    s00_axi_wready  = 1'b0;
    s00_axi_bvalid  = 1'b0;
    s00_axi_bid     = '0;
    s00_axi_bresp   = RESP_OKAY;
    ram_we          = 1'b0;
    case (wr_state_q)
      W_IDLE: begin
        s00_axi_awready = 1'b1;
        if (s00_axi_awvalid) begin
          wr_id_d    = s00_axi_awid;
          wr_idx_d   = 32'(s00_axi_awaddr[IDX_HI-1:ADDR_LSB]);
          wr_burst_d = s00_axi_awburst;
          wr_len_d   = s00_axi_awlen;
          wr_cnt_d   = '0;
          wr_resp_d  = classify(s00_axi_awaddr[AWIDTH-1:IDX_HI], s00_axi_awsize,
                                s00_axi_awburst, s00_axi_awlen);
          wr_proto_d = 1'b0;
          wr_over_d  = 1'b0;
          wr_state_d = W_DATA;
        end
      end
      W_DATA: begin
        s00_axi_wready = 1'b1;
        if (s00_axi_wvalid) begin
          ram_we   = (wr_resp_q == RESP_OKAY) && !wr_over_q;
          wr_idx_d = wr_next;
          wr_cnt_d = wr_cnt_q + 8'd1;
          // Beats past awlen+1 are absorbed without writing until wlast shows up.
          if (s00_axi_wlast) begin
            wr_state_d = W_RESP;
            if (!wr_over_q && (wr_cnt_q != wr_len_q)) begin
              wr_proto_d = 1'b1;
            end
          end else if (!wr_over_q && (wr_cnt_q == wr_len_q)) begin
            wr_over_d  = 1'b1;
            wr_proto_d = 1'b1;
          end
        end
      end
      W_RESP: begin
        s00_axi_bvalid = 1'b1;
        s00_axi_bid    = wr_id_q;
        s00_axi_bresp  = (wr_resp_q != RESP_OKAY) ? wr_resp_q :
                         (wr_proto_q ? RESP_SLVERR : RESP_OKAY);
        if (s00_axi_bready) begin
          wr_state_d = W_IDLE;
        end
      end
      default: wr_state_d = W_IDLE;
    endcase
  end

  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      wr_state_q <= W_IDLE;
      wr_id_q    <= '0;
      wr_idx_q   <= '0;
      wr_burst_q <= '0;
      wr_len_q   <= '0;
      wr_cnt_q   <= '0;
      wr_resp_q  <= '0;
      wr_proto_q <= 1'b0;
      wr_over_q  <= 1'b0;
    end else begin
      wr_state_q <= wr_state_d;
      wr_id_q    <= wr_id_d;
      wr_idx_q   <= wr_idx_d;
      wr_burst_q <= wr_burst_d;
      wr_len_q   <= wr_len_d;
      wr_cnt_q   <= wr_cnt_d;
      wr_resp_q  <= wr_resp_d;
      wr_proto_q <= wr_proto_d;
      wr_over_q  <= wr_over_d;
    end
  end

  // ---------------- read channel ----------------
  rd_state_e       rd_state_q, rd_state_d;
  logic [IWIDTH-1:0] rd_id_q, rd_id_d;
  logic [31:0]     rd_idx_q, rd_idx_d, rd_next;
  logic [1:0]      rd_burst_q, rd_burst_d;
  logic [7:0]      rd_len_q, rd_len_d;
  logic [7:0]      rd_cnt_q, rd_cnt_d;
  logic [1:0]      rd_resp_q, rd_resp_d;

  always_comb begin
    rd_state_d = rd_state_q;
    rd_id_d    = rd_id_q;
    rd_idx_d   = rd_idx_q;
    rd_burst_d = rd_burst_q;
    rd_len_d   = rd_len_q;
    rd_cnt_d   = rd_cnt_q;
    rd_resp_d  = rd_resp_q;
    rd_next    = next_addr(rd_idx_q, rd_burst_q, rd_len_q) & DEPTH_MASK;
    ram_re     = 1'b0;
    ram_raddr  = rd_idx_q[DEPTH_LOG2-1:0];
    s00_axi_arready = 1'b0;
    s00_axi_rvalid  = 1'b0;
    s00_axi_rlast   = 1'b0;
    s00_axi_rid     = '0;
    s00_axi_rresp   = RESP_OKAY;
    s00_axi_rdata   = '0;
    case (rd_state_q)
      R_IDLE: begin
        s00_axi_arready = 1'b1;
        if (s00_axi_arvalid) begin
          rd_id_d    = s00_axi_arid;
          rd_idx_d   = 32'(s00_axi_araddr[IDX_HI-1:ADDR_LSB]);
          rd_burst_d = s00_axi_arburst;
          rd_len_d   = s00_axi_arlen;
          rd_cnt_d   = '0;
          rd_resp_d  = classify(s00_axi_araddr[AWIDTH-1:IDX_HI], s00_axi_arsize,
                                s00_axi_arburst, s00_axi_arlen);
          rd_state_d = R_FETCH;
        end
      end
      R_FETCH: begin
        ram_re     = 1'b1;
        rd_state_d = R_DATA;
      end
      R_DATA: begin
        s00_axi_rvalid = 1'b1;
        s00_axi_rlast  = (rd_cnt_q == rd_len_q);
        s00_axi_rid    = rd_id_q;
        s00_axi_rresp  = rd_resp_q;
        s00_axi_rdata  = (rd_resp_q == RESP_OKAY) ? ram_rdata : '0;
        // The RAM output register only reloads on a handshake, so a stalled beat holds.
        if (s00_axi_rready) begin
          if (rd_cnt_q == rd_len_q) begin
            rd_state_d = R_IDLE;
          end else begin
            rd_cnt_d  = rd_cnt_q + 8'd1;
            rd_idx_d  = rd_next;
            ram_re    = 1'b1;
            ram_raddr = rd_next[DEPTH_LOG2-1:0];
          end
        end
      end
      default: rd_state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      rd_state_q <= R_IDLE;
      rd_id_q    <= '0;
      rd_idx_q   <= '0;
      rd_burst_q <= '0;
      rd_len_q   <= '0;
      rd_cnt_q   <= '0;
      rd_resp_q  <= '0;
    end else begin
      rd_state_q <= rd_state_d;
      rd_id_q    <= rd_id_d;
      rd_idx_q   <= rd_idx_d;
      rd_burst_q <= rd_burst_d;
      rd_len_q   <= rd_len_d;
      rd_cnt_q   <= rd_cnt_d;
      rd_resp_q  <= rd_resp_d;
    end
  end

  sram_dp_be #(
    .DWIDTH     (DWIDTH),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_ram (
    .clk   (s00_axi_aclk),
    .we    (ram_we),
    .waddr (wr_idx_q[DEPTH_LOG2-1:0]),
    .wdata (s00_axi_wdata),
    .wbe   (s00_axi_wstrb),
    .re    (ram_re),
    .raddr (ram_raddr),
    .rdata (ram_rdata)
  );

endmodule
